// File: rtl/shift_engine.sv
// Multi-step shift/rotate engine with a ready/valid command port and a held result.
// Optional LFSR op 000 compiled in with SHIFT_ENGINE_LFSR_EN; otherwise op 000 is a NOP.
`timescale 1ns/1ps
module shift_engine #(
    parameter int                 WIDTH     = 8,
    parameter int                 AMT_W     = 3,
    parameter logic [WIDTH-1:0]   LFSR_TAPS = WIDTH'(8'hB8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [WIDTH-1:0] in_din,
    input  logic             sin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    localparam logic [2:0] OP_LFSR = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSR  = 3'b010;
    localparam logic [2:0] OP_LSL  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_SIN  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_ROL  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_q, w_q_nxt;
    logic [AMT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]         r_op, w_op_nxt;
    logic               w_nop;

    // One single-bit step of the latched op applied to the held register.
    function automatic logic [WIDTH-1:0] f_step(input logic [2:0] op,
                                                input logic [WIDTH-1:0] q,
                                                input logic s);
        case (op)
            OP_LSR:  f_step = {1'b0, q[WIDTH-1:1]};
            OP_LSL:  f_step = {q[WIDTH-2:0], 1'b0};
            OP_ASR:  f_step = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_SIN:  f_step = {s, q[WIDTH-1:1]};
            OP_ROR:  f_step = {q[0], q[WIDTH-1:1]};
            OP_ROL:  f_step = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_LFSR: f_step = {q[WIDTH-2:0], ^(q & LFSR_TAPS)};
            default: f_step = q;
        endcase
    endfunction

`ifdef SHIFT_ENGINE_LFSR_EN
    assign w_nop = 1'b0;
`else
    // Without the LFSR, op 000 completes at the accept edge and never enters SHIFT.
    assign w_nop = (in_op == OP_LFSR);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_op_nxt = in_op;
                    if (in_op == OP_LOAD) begin
                        w_q_nxt     = in_din;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else if (w_nop || in_amt == '0) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt   = in_amt;
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_q_nxt   = f_step(r_op, r_q, sin);
                w_cnt_nxt = r_cnt - AMT_W'(1);
                if (r_cnt == AMT_W'(1))
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_SHIFT);
    assign dout      = r_q;

endmodule

// File: tb/tb_shift_engine.sv
// Randomized self-checking bench for shift_engine against a behavioural model
// (WIDTH=8, AMT_W=4 so counts beyond WIDTH are exercised).
`timescale 1ns/1ps
module tb_shift_engine;

    localparam logic [7:0] TAPS = 8'hB8;
`ifdef SHIFT_ENGINE_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, sin, out_valid, out_ready, busy;
    logic [2:0] in_op;
    logic [3:0] in_amt;
    logic [7:0] in_din, dout;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] m_q;

    shift_engine #(.WIDTH(8), .AMT_W(4), .LFSR_TAPS(TAPS)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_amt(in_amt), .in_din(in_din), .sin(sin),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_step(input logic [2:0] op, input logic [7:0] q, input logic s);
        case (op)
            3'b010:  return q >> 1;
            3'b011:  return q << 1;
            3'b100:  return 8'($signed(q) >>> 1);
            3'b101:  return (q >> 1) | (8'(s) << 7);
            3'b110:  return (q >> 1) | (q << 7);
            3'b111:  return (q << 1) | (q >> 7);
            default: return (q << 1) | 8'($countones(q & TAPS) % 2);
        endcase
    endfunction

    // Issue one command, follow it to the result, hold the result for `hold` cycles, then consume it.
    task automatic run_cmd(input logic [2:0] op, input int amt, input logic [7:0] din,
                           input logic [15:0] sb, input int hold);
        logic [7:0] exp_q;
        int exp_n;
        int n;
        exp_q = m_q;
        exp_n = 0;
        if (op == 3'b001) exp_q = din;
        else if (op != 3'b000 || LFSR_ON) begin
            exp_n = amt;
            for (int k = 0; k < amt; k++) exp_q = model_step(op, exp_q, sb[k]);
        end
        chk("rdy_idle", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_amt = 4'(amt); in_din = din;
        @(posedge clk); #1;
        in_valid = 1'(($urandom % 2));
        in_op = 3'($urandom); in_amt = 4'($urandom); in_din = 8'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            chk("busy_hi", busy, 1);
            chk("rdy_lo_shift", in_ready, 0);
            sin = sb[n % 16];
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, exp_n);
        chk("ovalid", out_valid, 1);
        chk("dout", dout, exp_q);
        chk("busy_lo", busy, 0);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_dout", dout, exp_q);
            chk("hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("ovalid_clr", out_valid, 0);
        chk("rdy_back", in_ready, 1);
        chk("dout_keep", dout, exp_q);
        m_q = exp_q;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_op = 0; in_amt = 0; in_din = 0; sin = 0; out_ready = 0;
        m_q = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(3'b001, 3, 8'hA5, 16'h0, 1);
        chk("load_a5", dout, 8'hA5);

        run_cmd(3'b001, 0, 8'h96, 16'h0, 0);
        run_cmd(3'b100, 3, 8'h00, 16'h0, 5);
        chk("asr_f2", dout, 8'hF2);

        run_cmd(3'b001, 0, 8'h3C, 16'h0, 0);
        run_cmd(3'b111, 4, 8'h00, 16'h0, 2);
        chk("rol_c3", dout, 8'hC3);
        run_cmd(3'b010, 0, 8'h00, 16'h0, 1);
        chk("amt0_c3", dout, 8'hC3);

        run_cmd(3'b101, 8, 8'h00, 16'h008D, 0);
        chk("sin_8d", dout, 8'h8D);

        run_cmd(3'b110, 11, 8'h00, 16'h0, 0);
        run_cmd(3'b011, 12, 8'h00, 16'h0, 0);
        chk("lsl_long", dout, 8'h00);

        run_cmd(3'b001, 0, 8'h80, 16'h0, 0);
        if (LFSR_ON) begin
            run_cmd(3'b000, 1, 8'h00, 16'h0, 0);
            chk("lfsr_01", dout, 8'h01);
        end else begin
            run_cmd(3'b000, 5, 8'h00, 16'h0, 0);
            chk("nop_80", dout, 8'h80);
        end

        // Abort a shift with an asynchronous reset mid-command.
        run_cmd(3'b001, 0, 8'hFF, 16'h0, 0);
        in_valid = 1'b1; in_op = 3'b010; in_amt = 4'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_busy", busy, 1);
        chk("abort_mid", dout, 8'h3F);
        #2 rst = 1'b1;
        #1;
        chk("abort_dout", dout, 0);
        chk("abort_ovalid", out_valid, 0);
        chk("abort_rdy", in_ready, 1);
        chk("abort_busy0", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            chk("abort_noresult", out_valid, 0);
        end
        out_ready = 1'b0;
        m_q = 8'h00;

        for (int i = 0; i < 80; i++) begin
            run_cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    8'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
